// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use/branch/multiply stall and flush control.
// Forwarding, stall and flush outputs are combinational (zero cycles); mult_busy and stall_count are registered.
// Stalls hold Fetch/Decode and bubble Execute; a pending multiply stalls HI/LO readers and back-to-back multiplies.
module hazard_unit #(
  parameter int MULT_CYCLES = 32
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        PCSrcD,
  input  logic        start_multD,
  input  logic        start_multE,
  input  logic [1:0]  Out_selectD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        mult_busy,
  output logic [15:0] stall_count
);

  typedef enum logic {IDLE, BUSY} mstate_t;

  // Counter reload: BUSY covers the cycles after the start edge; the start
  // cycle itself is covered by start_multE directly.
  localparam logic [7:0] MCNT_LOAD = 8'(MULT_CYCLES - 1);

  mstate_t     state_q, state_d;
  logic [7:0]  mcnt_q, mcnt_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic lwstall, branchstall, multstall, stall;

  assign mult_busy   = (state_q == BUSY);
  assign stall_count = stall_count_q;

  // Stall sources; everything is gated off while reset is held.
  always_comb begin
    lwstall     = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
    branchstall = BranchD &&
                  ((RegWriteE && (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                   (MemtoRegM && (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    multstall   = (mult_busy || start_multE) && ((Out_selectD != 2'b00) || start_multD);
    stall       = !reset && (lwstall || branchstall || multstall);
  end

  // Forwarding selects and pipeline control; Memory stage beats Writeback.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    StallF    = stall;
    StallD    = stall;
    FlushE    = stall;
    // A branch that is still waiting on its operands must not flush yet.
    FlushD    = !reset && PCSrcD && !stall;
    if (!reset) begin
      if ((RsE != 5'd0) && RegWriteM && (RsE == WriteRegM))      ForwardAE = 2'b10;
      else if ((RsE != 5'd0) && RegWriteW && (RsE == WriteRegW)) ForwardAE = 2'b01;
      if ((RtE != 5'd0) && RegWriteM && (RtE == WriteRegM))      ForwardBE = 2'b10;
      else if ((RtE != 5'd0) && RegWriteW && (RtE == WriteRegW)) ForwardBE = 2'b01;
      ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
      ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);
    end
  end

  // Multiplier occupancy FSM; a restart while busy reloads the counter.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      IDLE: begin
        if (start_multE) begin
          state_d = BUSY;
          mcnt_d  = MCNT_LOAD;
        end
      end
      BUSY: begin
        if (start_multE) begin
          mcnt_d = MCNT_LOAD;
        end else if (mcnt_q == 8'd1) begin
          state_d = IDLE;
          mcnt_d  = 8'd0;
        end else begin
          mcnt_d = mcnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        mcnt_d  = 8'd0;
      end
    endcase
    if (reset) begin
      state_d = IDLE;
      mcnt_d  = 8'd0;
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (reset) begin
      stall_count_d = 16'd0;
    end else if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State registers; reset is folded into the next-state logic above.
  always_ff @(posedge CLK) begin
    state_q       <= state_d;
    mcnt_q        <= mcnt_d;
    stall_count_q <= stall_count_d;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (MULT_CYCLES 4 and 32) driven by shared stimulus.
// Expected outputs come from a behavioural model, queued at drive time and compared at the falling edge.
// Directed scenarios for forwarding, load-use, branch, multiply, reset abort and saturation, then random traffic.
module tb_hazard_unit;

  localparam int NDUT = 2;
  int mc [NDUT] = '{4, 32};

  logic        CLK = 1'b0;
  logic        reset;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic        BranchD, PCSrcD, start_multD, start_multE;
  logic [1:0]  Out_selectD;

  logic        sf [NDUT], sd [NDUT], fd [NDUT], fe [NDUT], fad [NDUT], fbd [NDUT], mb [NDUT];
  logic [1:0]  fae [NDUT], fbe [NDUT];
  logic [15:0] sc [NDUT];

  typedef struct packed {
    logic sf, sd, fd, fe;
    logic [1:0] fae, fbe;
    logic fad, fbd, mb;
    logic [15:0] sc;
  } exp_t;

  exp_t sbq[$];
  int   m_left [NDUT];
  int   m_cnt  [NDUT];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 CLK = ~CLK;

  hazard_unit #(.MULT_CYCLES(4)) u_dut4 (
    .CLK(CLK), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .start_multD(start_multD), .start_multE(start_multE),
    .Out_selectD(Out_selectD),
    .StallF(sf[0]), .StallD(sd[0]), .FlushD(fd[0]), .FlushE(fe[0]),
    .ForwardAE(fae[0]), .ForwardBE(fbe[0]), .ForwardAD(fad[0]), .ForwardBD(fbd[0]),
    .mult_busy(mb[0]), .stall_count(sc[0])
  );

  hazard_unit #(.MULT_CYCLES(32)) u_dut32 (
    .CLK(CLK), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .start_multD(start_multD), .start_multE(start_multE),
    .Out_selectD(Out_selectD),
    .StallF(sf[1]), .StallD(sd[1]), .FlushD(fd[1]), .FlushE(fe[1]),
    .ForwardAE(fae[1]), .ForwardBE(fbe[1]), .ForwardAD(fad[1]), .ForwardBD(fbd[1]),
    .mult_busy(mb[1]), .stall_count(sc[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    if (r != 5'd0 && RegWriteM && r == WriteRegM) return 2'b10;
    if (r != 5'd0 && RegWriteW && r == WriteRegW) return 2'b01;
    return 2'b00;
  endfunction

  // Model of the expected outputs for instance k from current inputs and model state.
  function automatic exp_t calc_exp(input int k);
    exp_t e;
    logic lw, br, mu, st;
    e    = '0;
    e.mb = (m_left[k] > 0);
    e.sc = m_cnt[k][15:0];
    if (!reset) begin
      lw = MemtoRegE && RtE != 5'd0 && (RtE == RsD || RtE == RtD);
      br = BranchD && ((RegWriteE && WriteRegE != 5'd0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                       (MemtoRegM && WriteRegM != 5'd0 && (WriteRegM == RsD || WriteRegM == RtD)));
      mu = (e.mb || start_multE) && (Out_selectD != 2'b00 || start_multD);
      st = lw || br || mu;
      e.sf  = st;
      e.sd  = st;
      e.fe  = st;
      e.fd  = PCSrcD && !st;
      e.fae = fwd_e(RsE);
      e.fbe = fwd_e(RtE);
      e.fad = RsD != 5'd0 && RegWriteM && RsD == WriteRegM;
      e.fbd = RtD != 5'd0 && RegWriteM && RtD == WriteRegM;
    end
    return e;
  endfunction

  // Queue expectations for the current inputs, then compare at the falling edge.
  task automatic step();
    exp_t e;
    for (int k = 0; k < NDUT; k++) sbq.push_back(calc_exp(k));
    @(negedge CLK);
    for (int k = 0; k < NDUT; k++) begin
      e = sbq.pop_front();
      check($sformatf("StallF/%0d", mc[k]),      32'(sf[k]),  32'(e.sf));
      check($sformatf("StallD/%0d", mc[k]),      32'(sd[k]),  32'(e.sd));
      check($sformatf("FlushD/%0d", mc[k]),      32'(fd[k]),  32'(e.fd));
      check($sformatf("FlushE/%0d", mc[k]),      32'(fe[k]),  32'(e.fe));
      check($sformatf("ForwardAE/%0d", mc[k]),   32'(fae[k]), 32'(e.fae));
      check($sformatf("ForwardBE/%0d", mc[k]),   32'(fbe[k]), 32'(e.fbe));
      check($sformatf("ForwardAD/%0d", mc[k]),   32'(fad[k]), 32'(e.fad));
      check($sformatf("ForwardBD/%0d", mc[k]),   32'(fbd[k]), 32'(e.fbd));
      check($sformatf("mult_busy/%0d", mc[k]),   32'(mb[k]),  32'(e.mb));
      check($sformatf("stall_count/%0d", mc[k]), 32'(sc[k]),  32'(e.sc));
    end
  endtask

  // Advance one clock edge and update the model state with the same inputs.
  task automatic tick();
    exp_t e [NDUT];
    for (int k = 0; k < NDUT; k++) e[k] = calc_exp(k);
    @(posedge CLK);
    for (int k = 0; k < NDUT; k++) begin
      if (reset) begin
        m_left[k] = 0;
        m_cnt[k]  = 0;
      end else begin
        if (e[k].sf && m_cnt[k] < 65535) m_cnt[k]++;
        if (start_multE)       m_left[k] = mc[k] - 1;
        else if (m_left[k] > 0) m_left[k]--;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; PCSrcD = 0; start_multD = 0; start_multE = 0; Out_selectD = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin m_left[k] = 0; m_cnt[k] = 0; end
    clear_inputs();
    reset = 1;
    tick();
    // Reset forces control outputs low even with hazardous inputs present.
    RsE = 5'd3; RtE = 5'd3; RegWriteM = 1; WriteRegM = 5'd3; MemtoRegE = 1; RsD = 5'd3;
    PCSrcD = 1; Out_selectD = 2'b01; start_multE = 1;
    step();
    check("rst_stall", 32'(sf[0]), 32'd0);
    check("rst_fwdAE", 32'(fae[1]), 32'd0);
    check("rst_cnt",   32'(sc[1]), 32'd0);
    tick();
    do_reset();

    // Forward priority: Memory over Writeback, register 0 never forwarded.
    RsE = 5'd3; RtE = 5'd3; RegWriteM = 1; WriteRegM = 5'd3; RegWriteW = 1; WriteRegW = 5'd3;
    step(); check("fwd_mem", 32'(fae[0]), 32'd2); tick();
    RegWriteM = 0;
    step(); check("fwd_wb", 32'(fae[0]), 32'd1); tick();
    RsE = 5'd0; RegWriteM = 1; WriteRegM = 5'd0; WriteRegW = 5'd0;
    step(); check("fwd_zero", 32'(fae[0]), 32'd0); tick();
    RsD = 5'd9; RtD = 5'd9; WriteRegM = 5'd9; RtE = 5'd9;
    step(); check("fwd_ad", 32'(fad[0]), 32'd1); check("fwd_bd", 32'(fbd[0]), 32'd1); tick();
    do_reset();

    // Load-use stall for one cycle.
    MemtoRegE = 1; RtE = 5'd5; RsD = 5'd5;
    step(); check("lu_stall", 32'(sf[0]), 32'd1); check("lu_flushE", 32'(fe[0]), 32'd1); tick();
    MemtoRegE = 0;
    step(); check("lu_clear", 32'(sd[0]), 32'd0); check("lu_cnt", 32'(sc[0]), 32'd1); tick();
    MemtoRegE = 1; RtE = 5'd0; RsD = 5'd0;
    step(); tick();
    RtE = 5'd6; RtD = 5'd6;
    step(); tick();
    do_reset();

    // Branch waits on an Execute producer, then flushes once resolved.
    BranchD = 1; RsD = 5'd7; RegWriteE = 1; WriteRegE = 5'd7; PCSrcD = 1;
    step(); check("br_stall", 32'(sf[0]), 32'd1); check("br_noflush", 32'(fd[0]), 32'd0); tick();
    RegWriteE = 0;
    step(); check("br_go", 32'(sf[0]), 32'd0); check("br_flush", 32'(fd[0]), 32'd1); tick();
    MemtoRegM = 1; WriteRegM = 5'd7; PCSrcD = 0; RsD = 5'd1; RtD = 5'd7;
    step(); tick();
    do_reset();

    // Multiply with a HI/LO reader held in Decode.
    start_multE = 1; Out_selectD = 2'b01;
    for (int c = 0; c <= 4; c++) begin
      step();
      check($sformatf("mul_stall_c%0d", c), 32'(sf[0]), 32'((c <= 3) ? 1 : 0));
      check($sformatf("mul_busy_c%0d", c),  32'(mb[0]), 32'((c >= 1 && c <= 3) ? 1 : 0));
      tick();
      start_multE = 0;
    end
    // Back-to-back multiply and a restart while busy.
    Out_selectD = 2'b00; start_multE = 1;
    step(); tick();
    start_multE = 0; start_multD = 1;
    step(); tick();
    start_multE = 1; start_multD = 0;
    step(); tick();
    start_multE = 0; Out_selectD = 2'b10;
    for (int c = 0; c < 5; c++) begin step(); tick(); end
    do_reset();

    // Reset during a long multiply aborts it.
    start_multE = 1; Out_selectD = 2'b01;
    step(); tick();
    start_multE = 0;
    step(); tick();
    reset = 1;
    step(); check("abort_rst_stall", 32'(sf[1]), 32'd0); tick();
    reset = 0;
    step();
    check("abort_busy",  32'(mb[1]), 32'd0);
    check("abort_cnt",   32'(sc[1]), 32'd0);
    check("abort_stall", 32'(sf[1]), 32'd0);
    tick();

    // Random traffic on a small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 39) == 0);
      RsD         = 5'($urandom_range(0, 3));
      RtD         = 5'($urandom_range(0, 3));
      RsE         = 5'($urandom_range(0, 3));
      RtE         = 5'($urandom_range(0, 3));
      WriteRegE   = 5'($urandom_range(0, 3));
      WriteRegM   = 5'($urandom_range(0, 3));
      WriteRegW   = 5'($urandom_range(0, 3));
      RegWriteE   = 1'($urandom_range(0, 1));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      MemtoRegE   = ($urandom_range(0, 3) == 0);
      MemtoRegM   = ($urandom_range(0, 3) == 0);
      BranchD     = 1'($urandom_range(0, 1));
      PCSrcD      = 1'($urandom_range(0, 1));
      start_multD = ($urandom_range(0, 7) == 0);
      start_multE = ($urandom_range(0, 11) == 0);
      Out_selectD = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step();
      tick();
    end
    do_reset();

    // Saturation: hold a load-use stall far beyond the counter range.
    MemtoRegE = 1; RtE = 5'd5; RsD = 5'd5;
    for (int i = 0; i < 70000; i++) tick();
    step(); check("sat_cnt", 32'(sc[0]), 32'h0000FFFF); tick();
    step(); check("sat_hold", 32'(sc[1]), 32'h0000FFFF); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 32, the multiplier latency in cycles from start_multE to HI/LO valid (legal range 2..255).
REQ-002 SHALL have CLK, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-003 SHALL have reset, input, 1 bit, a synchronous, active-high reset.
REQ-004 SHALL have inputs RsD, RtD, RsE, RtE, WriteRegE, WriteRegM and WriteRegW, each 5 bits, the register specifiers of the Decode/Execute operands and of the Execute/Memory/Writeback destinations.
REQ-005 SHALL have inputs RegWriteE, RegWriteM, RegWriteW, MemtoRegE and MemtoRegM, each 1 bit, the per-stage write-enable and load flags.
REQ-006 SHALL have inputs BranchD, PCSrcD, start_multD and start_multE, each 1 bit: branch in Decode, branch taken, and multiply in Decode/Execute.
REQ-007 SHALL have input Out_selectD, 2 bits; a nonzero value marks the Decode instruction as a HI/LO reader.
REQ-008 SHALL have outputs StallF and StallD, each 1 bit, the active-high hold for the Fetch PC and the F/D register.
REQ-009 SHALL have outputs FlushD and FlushE, each 1 bit, which clear the F/D register and drive the CLR input of the D/E register.
REQ-010 SHALL have outputs ForwardAE and ForwardBE, each 2 bits, the Execute operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-011 SHALL have outputs ForwardAD and ForwardBD, each 1 bit, which forward the Memory ALU result into the Decode branch comparator.
REQ-012 SHALL have output mult_busy, 1 bit, registered, high while the multiplier is computing.
REQ-013 SHALL have output stall_count, 16 bits, a registered count of stall cycles.

Function
REQ-014 ForwardAE SHALL be 10 when RsE!=0 and RegWriteM and RsE==WriteRegM; otherwise 01 when RsE!=0 and RegWriteW and RsE==WriteRegW; otherwise 00. The Memory stage has priority. ForwardBE SHALL follow the same rule using RtE.
REQ-015 ForwardAD SHALL be RsD!=0 && RegWriteM && RsD==WriteRegM; ForwardBD SHALL be the same rule using RtD.
REQ-016 lwstall SHALL be MemtoRegE && RtE!=0 && (RtE==RsD || RtE==RtD).
REQ-017 branchstall SHALL be BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE in {RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM in {RsD,RtD})).
REQ-018 multstall SHALL be (mult_busy || start_multE) && (Out_selectD!=0 || start_multD).
REQ-019 stall SHALL be lwstall || branchstall || multstall; StallF = StallD = stall; FlushE = stall.
REQ-020 FlushD SHALL be PCSrcD && !stall, so a stalled branch is not flushed early.
REQ-021 The multiplier FSM SHALL have the states IDLE and BUSY and an 8-bit down-counter mcnt.
REQ-022 In IDLE, start_multE SHALL move the FSM to BUSY on the next edge with mcnt = MULT_CYCLES-1.
REQ-023 In BUSY, mcnt SHALL decrement each cycle; at mcnt==1 the FSM SHALL return to IDLE on the next edge. BUSY therefore lasts MULT_CYCLES-1 cycles after the start edge, and the first cycle is covered combinationally by start_multE.
REQ-024 mult_busy SHALL be 1 exactly while the FSM is in BUSY.
REQ-025 If start_multE is asserted while in BUSY (protocol violation), the FSM SHALL reload mcnt = MULT_CYCLES-1 and remain in BUSY.
REQ-026 stall_count SHALL increment by 1 on each edge where stall==1, and SHALL saturate at 16'hFFFF with no wrap-around.
REQ-027 All outputs other than mult_busy and stall_count SHALL be combinational from the current inputs and state, with zero-cycle latency.

Reset
REQ-028 While reset==1, StallF, StallD, FlushD, FlushE, ForwardAD and ForwardBD SHALL be forced to 0, and ForwardAE and ForwardBE SHALL be forced to 00.
REQ-029 On the first edge with reset==1, the FSM SHALL go to IDLE with mcnt=0, mult_busy=0 and stall_count=0.
REQ-030 A reset during BUSY SHALL abort the multiply immediately; the FSM SHALL be in IDLE on the next cycle with no residual stall.

Verification
REQ-031 Load-use: MemtoRegE=1, RtE=5, RsD=5 -> StallF=StallD=FlushE=1 for that cycle; the next cycle with MemtoRegE=0 -> all three are 0; stall_count=1.
REQ-032 Forward priority: RsE=3, RegWriteM=1, WriteRegM=3, RegWriteW=1, WriteRegW=3 -> ForwardAE=10. With RegWriteM=0 -> 01. With RsE=0 -> 00 regardless of the other inputs.
REQ-033 Branch: BranchD=1, RsD=7, RegWriteE=1, WriteRegE=7, PCSrcD=1 -> stall=1, FlushD=0. The next cycle with RegWriteE=0 -> stall=0, FlushD=1.
REQ-034 Multiply with MULT_CYCLES=4: start_multE pulsed at cycle 0 and Out_selectD=01 held -> stall high in cycles 0-3 and low in cycle 4; mult_busy high in cycles 1-3.
REQ-035 Reset mid-multiply: reset asserted at cycle 2 of a MULT_CYCLES=32 operation -> mult_busy=0 and stall_count=0 after the edge; Out_selectD=01 causes no stall afterwards.
REQ-036 Saturation: force 70000 stall cycles -> stall_count holds at 16'hFFFF.
